// File: rtl/seq_shift_if.sv
// Handshake and data bundle for the sequential shift unit.
// The slave modport is the shifter side; the master modport is the requester/consumer side.
interface seq_shift_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [SHAMT_W-1:0] B;
  logic [1:0]         sel;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out;
  logic               busy;

  modport master (
    output in_valid, A, B, sel, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, A, B, sel, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/seq_shift.sv
// Multi-cycle SRL/SRA/SLL unit shifting up to STEP bits per clock, valid/ready on both sides.
// Define SEQ_SHIFT_ROTATE_EN to turn sel = 11 into rotate-right; otherwise sel = 11 returns 0.
module seq_shift #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned STEP    = 1
) (
  input  logic       clk,
  input  logic       rst,
  seq_shift_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // One extra bit so STEP and WIDTH both fit regardless of SHAMT_W.
  localparam logic [SHAMT_W:0] StepVal  = (SHAMT_W + 1)'(STEP);
  localparam logic [SHAMT_W:0] WidthVal = (SHAMT_W + 1)'(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [1:0]         op_q, op_d;
  logic [SHAMT_W:0]   k;
  logic [WIDTH-1:0]   shifted;
  logic               reserved_in;
  logic               reserved_op;

  always_comb begin
    k = ({1'b0, count_q} > StepVal) ? StepVal : {1'b0, count_q};
  end

  always_comb begin
    shifted = data_q;
    case (op_q)
      2'b00:   shifted = data_q >> k;
      2'b01:   shifted = $signed(data_q) >>> k;
      2'b10:   shifted = data_q << k;
      default: begin
`ifdef SEQ_SHIFT_ROTATE_EN
        shifted = (data_q >> k) | (data_q << (WidthVal - k));
`else
        shifted = data_q;
`endif
      end
    endcase
  end

`ifdef SEQ_SHIFT_ROTATE_EN
  assign reserved_in = 1'b0;
  assign reserved_op = 1'b0;
`else
  assign reserved_in = (bus.sel == 2'b11);
  assign reserved_op = (op_q == 2'b11);
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    op_d    = op_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          data_d  = bus.A;
          count_d = bus.B;
          op_d    = bus.sel;
          state_d = ((bus.B == '0) || reserved_in) ? StDone : StShift;
        end
      end
      StShift: begin
        data_d  = shifted;
        count_d = count_q - k[SHAMT_W-1:0];
        if (count_d == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      count_q <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out       = (bus.out_valid && !reserved_op) ? data_q : '0;

endmodule

// File: tb/tb_seq_shift.sv
// Directed and lightly randomised checks of seq_shift with STEP = 1 and STEP = 4 instances.
module tb_seq_shift;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  seq_shift_if #(.WIDTH(32), .SHAMT_W(5)) if1 ();
  seq_shift_if #(.WIDTH(32), .SHAMT_W(5)) if4 ();

  seq_shift #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  seq_shift #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int d, input logic v, input logic [31:0] a, input logic [4:0] b,
                         input logic [1:0] s);
    if (d == 4) begin
      if4.in_valid = v; if4.A = a; if4.B = b; if4.sel = s;
    end else begin
      if1.in_valid = v; if1.A = a; if1.B = b; if1.sel = s;
    end
  endtask

  task automatic set_ordy(input int d, input logic r);
    if (d == 4) if4.out_ready = r;
    else        if1.out_ready = r;
  endtask

  task automatic samp(input int d, output logic ov, output logic [31:0] o, output logic ir,
                      output logic bz);
    if (d == 4) begin
      ov = if4.out_valid; o = if4.out; ir = if4.in_ready; bz = if4.busy;
    end else begin
      ov = if1.out_valid; o = if1.out; ir = if1.in_ready; bz = if1.busy;
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] b,
                                            input logic [1:0] s);
    case (s)
      2'b00:   return a >> b;
      2'b01:   return $signed(a) >>> b;
      2'b10:   return a << b;
      default: begin
`ifdef SEQ_SHIFT_ROTATE_EN
        return (a >> b) | (a << (32 - int'(b)));
`else
        return 32'h0;
`endif
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] b, input logic [1:0] s, input int step);
`ifndef SEQ_SHIFT_ROTATE_EN
    if (s == 2'b11) return 1;
`endif
    return (int'(b) + step - 1) / step + 1;
  endfunction

  // Issues one op, waits for the result, optionally stalls the consumer, then retires it.
  task automatic run_op(input int d, input logic [31:0] a, input logic [4:0] b,
                        input logic [1:0] s, input int hold, input bit keep_valid,
                        output logic [31:0] res, output int lat);
    logic ov, ir, bz;
    logic [31:0] o;
    int w;
    set_req(d, 1'b1, a, b, s);
    samp(d, ov, o, ir, bz);
    w = 0;
    while (!ir && w < 100) begin
      @(posedge clk); #1;
      samp(d, ov, o, ir, bz);
      w++;
    end
    @(posedge clk); #1;
    if (!keep_valid) set_req(d, 1'b0, 32'h0, 5'd0, 2'b00);
    samp(d, ov, o, ir, bz);
    check("busy_after_accept", {31'd0, bz}, 32'd1);
    lat = 1;
    while (!ov && lat < 64) begin
      if (o != 32'h0) check("out_zero_while_invalid", o, 32'h0);
      @(posedge clk); #1;
      samp(d, ov, o, ir, bz);
      lat++;
    end
    check("out_valid_rises", {31'd0, ov}, 32'd1);
    res = o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      samp(d, ov, o, ir, bz);
      check("hold_out_stable", o, res);
      check("hold_in_ready_low", {31'd0, ir}, 32'd0);
      check("hold_valid_high", {31'd0, ov}, 32'd1);
    end
    set_ordy(d, 1'b1);
    @(posedge clk); #1;
    set_ordy(d, 1'b0);
    if (keep_valid) set_req(d, 1'b0, 32'h0, 5'd0, 2'b00);
    samp(d, ov, o, ir, bz);
    check("retire_valid_low", {31'd0, ov}, 32'd0);
    check("retire_in_ready", {31'd0, ir}, 32'd1);
  endtask

  initial begin
    logic [31:0] res, o;
    logic ov, ir, bz, seen;
    int lat, d;
    logic [31:0] a;
    logic [4:0]  b;
    logic [1:0]  s;

    set_req(1, 1'b0, 32'h0, 5'd0, 2'b00);
    set_req(4, 1'b0, 32'h0, 5'd0, 2'b00);
    set_ordy(1, 1'b0);
    set_ordy(4, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    samp(1, ov, o, ir, bz);
    check("rst_in_ready", {31'd0, ir}, 32'd1);
    check("rst_out_valid", {31'd0, ov}, 32'd0);
    check("rst_busy", {31'd0, bz}, 32'd0);
    check("rst_out", o, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(1, 32'hF000_0000, 5'd4, 2'b00, 0, 1'b0, res, lat);
    check("srl_res", res, 32'h0F00_0000);
    check("srl_lat", 32'(lat), 32'd5);

    run_op(1, 32'h8000_0010, 5'd31, 2'b01, 0, 1'b0, res, lat);
    check("sra31_s1_res", res, 32'hFFFF_FFFF);
    check("sra31_s1_lat", 32'(lat), 32'd32);

    run_op(4, 32'h8000_0010, 5'd31, 2'b01, 0, 1'b0, res, lat);
    check("sra31_s4_res", res, 32'hFFFF_FFFF);
    check("sra31_s4_lat", 32'(lat), 32'd9);

    run_op(1, 32'h1234_5678, 5'd0, 2'b10, 3, 1'b0, res, lat);
    check("sll0_res", res, 32'h1234_5678);
    check("sll0_lat", 32'(lat), 32'd1);

    run_op(1, 32'hDEAD_BEEF, 5'd8, 2'b11, 0, 1'b0, res, lat);
`ifdef SEQ_SHIFT_ROTATE_EN
    check("ror_res", res, 32'hEFDE_ADBE);
    check("ror_lat", 32'(lat), 32'd9);
`else
    check("reserved_res", res, 32'h0);
    check("reserved_lat", 32'(lat), 32'd1);
`endif

    // Abort an SLL three cycles in; no result may ever appear.
    set_req(1, 1'b1, 32'h1, 5'd20, 2'b10);
    @(posedge clk); #1;
    set_req(1, 1'b0, 32'h0, 5'd0, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    samp(1, ov, o, ir, bz);
    check("abort_in_ready", {31'd0, ir}, 32'd1);
    check("abort_out", o, 32'h0);
    check("abort_busy", {31'd0, bz}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      samp(1, ov, o, ir, bz);
      seen = seen | ov;
    end
    check("abort_no_result", {31'd0, seen}, 32'd0);

    run_op(1, 32'h1, 5'd3, 2'b10, 0, 1'b0, res, lat);
    check("sll3_res", res, 32'h0000_0008);
    check("sll3_lat", 32'(lat), 32'd4);

    // in_valid held through SHIFT/DONE and during retire: exactly one capture.
    run_op(4, 32'h8000_0000, 5'd5, 2'b00, 1, 1'b1, res, lat);
    check("held_srl_res", res, 32'h0400_0000);
    check("held_srl_lat", 32'(lat), 32'd3);
    @(posedge clk); #1;
    samp(4, ov, o, ir, bz);
    check("held_no_recapture", {31'd0, bz}, 32'd0);

    run_op(4, 32'hF000_0000, 5'd6, 2'b01, 0, 1'b0, res, lat);
    check("sra6_s4_res", res, 32'hFFC0_0000);
    check("sra6_s4_lat", 32'(lat), 32'd3);

    run_op(4, 32'h1, 5'd31, 2'b10, 0, 1'b0, res, lat);
    check("sll31_s4_res", res, 32'h8000_0000);
    check("sll31_s4_lat", 32'(lat), 32'd9);

    for (int i = 0; i < 48; i++) begin
      a = $urandom;
      b = 5'($urandom_range(0, 31));
      s = 2'($urandom_range(0, 3));
      d = (i % 2 == 1) ? 4 : 1;
      run_op(d, a, b, s, i % 3, 1'(i % 5 == 0), res, lat);
      check("rand_res", res, ref_shift(a, b, s));
      check("rand_lat", 32'(lat), 32'(exp_lat(b, s, d)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
